// File: rtl/pb_debounce_pkg.sv
// Shared definitions for the push-button debounce block: channel FSM
// states, counter sizing helper and the default qualification length.
package pb_debounce_pkg;

  // 1 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {
    REL_STABLE = 2'd0,
    PRESS_WAIT = 2'd1,
    PRS_STABLE = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  // Counter only ever holds 0..cycles-1, so clog2(cycles) bits suffice.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One button channel: 2-flop synchroniser, polarity normalisation,
// debounce FSM with qualification counter, press/release pulses and a
// sticky clearable interrupt flop.
// Build option: RELEASE_IRQ_EN -- when defined, accepted releases also
// raise the interrupt; otherwise only presses do.
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic btn_raw,
  input  logic irq_clr,
  output logic btn_clean,
  output logic btn_press,
  output logic btn_release,
  output logic btn_irq
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic          REL_LVL  = (BTN_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic          sync_q;
  db_state_e     state;
  logic [CW-1:0] cnt;
  logic          cnt_done;
  logic          press_evt;
  logic          rel_evt;
  logic          irq_set;

  // Synchroniser idles at the released pad level so reset never looks like a press
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) sync_ff <= {REL_LVL, REL_LVL};
    else          sync_ff <= {sync_ff[0], btn_raw};
  end

  // 1 = pressed regardless of pad polarity
  assign sync_q    = sync_ff[1] ^ REL_LVL;
  assign cnt_done  = (cnt == CNT_LAST);
  assign press_evt = (state == PRESS_WAIT) &&  sync_q && cnt_done;
  assign rel_evt   = (state == REL_WAIT)   && !sync_q && cnt_done;

`ifdef RELEASE_IRQ_EN
  assign irq_set = press_evt | rel_evt;
`else
  assign irq_set = press_evt;
`endif

  // Debounce FSM; all outputs registered, set beats clear on the irq flop
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state       <= REL_STABLE;
      cnt         <= '0;
      btn_clean   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_irq     <= 1'b0;
    end else begin
      btn_press   <= press_evt;
      btn_release <= rel_evt;
      btn_irq     <= irq_set | (btn_irq & ~irq_clr);
      case (state)
        REL_STABLE: begin
          if (sync_q) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync_q) begin
            state <= REL_STABLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state     <= PRS_STABLE;
            cnt       <= '0;
            btn_clean <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRS_STABLE: begin
          if (!sync_q) begin
            state <= REL_WAIT;
            cnt   <= CW'(1);
          end
        end
        REL_WAIT: begin
          if (sync_q) begin
            state <= PRS_STABLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state     <= REL_STABLE;
            cnt       <= '0;
            btn_clean <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= REL_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pb_debounce_irq.sv
// Push-button conditioning ahead of the basic I/O APB peripheral: one
// independent synchronise/debounce/irq channel per button pad.
// Build option: RELEASE_IRQ_EN (see pb_debounce_ch) -- releases also
// raise BTN_IRQ when defined.
module pb_debounce_irq
  import pb_debounce_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic               PCLK,
  input  logic               PRESETN,
  input  logic [NUM_BTN-1:0] BTN_RAW,
  input  logic [NUM_BTN-1:0] IRQ_CLR,
  output logic [NUM_BTN-1:0] BTN_CLEAN,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE,
  output logic [NUM_BTN-1:0] BTN_IRQ
);

  // One fully independent channel per button
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    pb_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_ch (
      .PCLK        (PCLK),
      .PRESETN     (PRESETN),
      .btn_raw     (BTN_RAW[g]),
      .irq_clr     (IRQ_CLR[g]),
      .btn_clean   (BTN_CLEAN[g]),
      .btn_press   (BTN_PRESS[g]),
      .btn_release (BTN_RELEASE[g]),
      .btn_irq     (BTN_IRQ[g])
    );
  end

endmodule

// File: tb/tb_pb_debounce_irq.sv
// Bench for pb_debounce_irq: directed scenarios plus random pad activity,
// checked every cycle against a run-length reference model via a queue.
module tb_pb_debounce_irq;

  localparam int NB = 2;
  localparam int D  = 8;
`ifdef RELEASE_IRQ_EN
  localparam bit REL_IRQ = 1'b1;
`else
  localparam bit REL_IRQ = 1'b0;
`endif
  localparam logic [NB-1:0] REL_VEC = '1;   // active-low pads idle high

  logic          PCLK = 1'b0;
  logic          PRESETN;
  logic [NB-1:0] BTN_RAW, IRQ_CLR;
  logic [NB-1:0] BTN_CLEAN, BTN_PRESS, BTN_RELEASE, BTN_IRQ;

  pb_debounce_irq #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .BTN_RAW(BTN_RAW), .IRQ_CLR(IRQ_CLR),
    .BTN_CLEAN(BTN_CLEAN), .BTN_PRESS(BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE), .BTN_IRQ(BTN_IRQ)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [NB-1:0] clean;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] irq;
  } exp_t;

  exp_t          exp_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;

  // reference model state: accepted level, length of the current run of
  // samples disagreeing with it, sticky irq, and the 2-edge sample delay
  logic [NB-1:0] raw_q[$];
  bit            m_clean[NB];
  int            m_run[NB];
  bit            m_irq[NB];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t          e;
    logic [NB-1:0] s;
    bit            set;
    e = '0;
    if (!PRESETN) begin
      raw_q.delete();
      raw_q.push_back(REL_VEC);
      raw_q.push_back(REL_VEC);
      for (int c = 0; c < NB; c++) begin
        m_clean[c] = 1'b0; m_run[c] = 0; m_irq[c] = 1'b0;
      end
    end else begin
      s = ~raw_q.pop_front();          // pressed = 1
      raw_q.push_back(BTN_RAW);
      for (int c = 0; c < NB; c++) begin
        if (s[c] != m_clean[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_clean[c] = s[c];
            m_run[c]   = 0;
            if (s[c]) e.press[c] = 1'b1;
            else      e.rel[c]   = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        set = e.press[c] | (REL_IRQ & e.rel[c]);
        if (set)             m_irq[c] = 1'b1;
        else if (IRQ_CLR[c]) m_irq[c] = 1'b0;
        e.clean[c] = m_clean[c];
        e.irq[c]   = m_irq[c];
      end
    end
    exp_q.push_back(e);
  endtask

  // model: one expected output vector per clock edge
  initial forever begin
    @(posedge PCLK);
    model_step();
  end

  // monitor: registered outputs are presented every cycle
  initial forever begin
    exp_t e;
    @(negedge PCLK);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if ({BTN_CLEAN, BTN_PRESS, BTN_RELEASE, BTN_IRQ} !== e) begin
        n_fail++;
        $display("FAIL scoreboard: got clean=%b press=%b rel=%b irq=%b expected clean=%b press=%b rel=%b irq=%b at %0t",
                 BTN_CLEAN, BTN_PRESS, BTN_RELEASE, BTN_IRQ, e.clean, e.press, e.rel, e.irq, $time);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
    #1;
  endtask

  // counts edges from the stimulus change until the pulse appears
  task automatic wait_pulse(input int ch, input bit rel, input int exp_k, input string name);
    int  k;
    bit  seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 60) begin
      @(negedge PCLK);
      if (rel ? BTN_RELEASE[ch] : BTN_PRESS[ch]) seen = 1'b1;
      else k++;
    end
    chk(name, seen ? k : -1, exp_k);
    #1;
  endtask

  initial begin
    bit any;
    int hold[NB];
    logic [NB-1:0] rv;

    PRESETN = 1'b0; BTN_RAW = REL_VEC; IRQ_CLR = '0;
    tick(3);
    chk("reset_outputs", int'({BTN_CLEAN, BTN_PRESS, BTN_RELEASE, BTN_IRQ}), 0);
    PRESETN = 1'b1;
    tick(3);

    // clean press: pulse, level and irq on edge 9
    BTN_RAW[0] = 1'b0;
    wait_pulse(0, 1'b0, 9, "clean_press_edge");
    chk("clean_press_level", int'(BTN_CLEAN[0]), 1);
    chk("clean_press_irq",   int'(BTN_IRQ[0]), 1);
    tick(1);
    chk("press_one_cycle", int'(BTN_PRESS[0]), 0);
    IRQ_CLR[0] = 1'b1; tick(1); IRQ_CLR[0] = 1'b0;
    chk("irq_clear", int'(BTN_IRQ[0]), 0);

    // release: irq only when release interrupts are built in
    BTN_RAW[0] = 1'b1;
    wait_pulse(0, 1'b1, 9, "release_edge");
    chk("release_level", int'(BTN_CLEAN[0]), 0);
    chk("release_irq",   int'(BTN_IRQ[0]), int'(REL_IRQ));
    IRQ_CLR = '1; tick(1); IRQ_CLR = '0; tick(2);

    // bounce: toggle every 3 cycles for 30 cycles, then hold pressed
    any = 1'b0;
    for (int j = 0; j < 10; j++) begin
      BTN_RAW[0] = (j % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) begin
        @(negedge PCLK);
        any |= BTN_PRESS[0] | BTN_CLEAN[0];
      end
      #1;
    end
    BTN_RAW[0] = 1'b0;
    wait_pulse(0, 1'b0, 9, "bounce_press_edge");
    chk("bounce_no_early", int'(any), 0);
    any = 1'b0;
    repeat (12) begin @(negedge PCLK); any |= BTN_PRESS[0]; end
    #1;
    chk("bounce_single_pulse", int'(any), 0);
    BTN_RAW[0] = 1'b1; tick(12);
    IRQ_CLR = '1; tick(1); IRQ_CLR = '0;

    // glitch on ch1: 5 low cycles are rejected
    any = 1'b0;
    BTN_RAW[1] = 1'b0;
    for (int j = 0; j < 25; j++) begin
      if (j == 5) BTN_RAW[1] = 1'b1;
      @(negedge PCLK);
      any |= BTN_CLEAN[1] | BTN_PRESS[1] | BTN_IRQ[1];
      #1;
    end
    chk("glitch_rejected", int'(any), 0);

    // clear coincident with a new press: set wins, lone clear then clears
    IRQ_CLR[0] = 1'b1;
    BTN_RAW[0] = 1'b0;
    wait_pulse(0, 1'b0, 9, "race_press_edge");
    chk("race_set_wins", int'(BTN_IRQ[0]), 1);
    IRQ_CLR[0] = 1'b0; tick(1);
    chk("race_irq_holds", int'(BTN_IRQ[0]), 1);
    IRQ_CLR[0] = 1'b1; tick(1); IRQ_CLR[0] = 1'b0;
    chk("lone_clear", int'(BTN_IRQ[0]), 0);

    // reset mid-qualification, then buttons held through deassertion
    BTN_RAW[0] = 1'b1; BTN_RAW[1] = 1'b0;
    tick(12);
    chk("ch1_pressed", int'({BTN_CLEAN[1], BTN_IRQ[1]}), 3);
    BTN_RAW[0] = 1'b0;
    tick(7);                              // ch0 count now at 5
    PRESETN = 1'b0; #1;
    chk("async_reset_outputs", int'({BTN_CLEAN, BTN_PRESS, BTN_RELEASE, BTN_IRQ}), 0);
    tick(2);
    PRESETN = 1'b1;
    wait_pulse(0, 1'b0, 9, "post_reset_press_edge");
    chk("post_reset_both", int'(BTN_PRESS), 3);

    // random pad activity and clears, checked by the scoreboard
    for (int c = 0; c < NB; c++) hold[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      rv = BTN_RAW;
      for (int c = 0; c < NB; c++) begin
        if (hold[c] == 0) begin
          rv[c]   = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 14);
        end else begin
          hold[c]--;
        end
      end
      BTN_RAW = rv;
      for (int c = 0; c < NB; c++) IRQ_CLR[c] = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    IRQ_CLR = '0;
    tick(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
